// File: rtl/pwm_output_stage_if.sv
// Register-side bundle for the PWM output stage: five control bytes in,
// 16 pin drives and the period marker out.
interface pwm_output_stage_if;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   modport master (
      output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
             pwm_duty_cycle,
      input  out, period_start
   );

   modport slave (
      input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
             pwm_duty_cycle,
      output out, period_start
   );
endinterface

// File: rtl/pwm_output_stage.sv
// Shared-waveform PWM driver for 16 user pins with per-pin enable/select.
// Optional PWM_SYNC_UPDATE_EN: duty is shadowed and only reloaded at period wrap.
module pwm_output_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic en_out_i,
   input  logic en_pwm_i,
   input  logic pwm_level_i,
   output logic out_o
);
   logic out_d, out_q;

   always_comb begin
      out_d = 1'b0;
      if (en_out_i) out_d = en_pwm_i ? pwm_level_i : 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) out_q <= 1'b0;
      else        out_q <= out_d;

   assign out_o = out_q;
endmodule

module pwm_output_stage #(
   parameter int PRESCALE = 13
) (
   input logic               clk,
   input logic               rst_n,
   pwm_output_stage_if.slave bus
);
   localparam int NUM_LANES = 16;
   localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0]          prescale_cnt_q, prescale_cnt_d;
   logic [7:0]             pwm_cnt_q, pwm_cnt_d;
   logic                   period_start_q;
   logic                   tick, wrap, pwm_level;
   logic [7:0]             duty_eff;
   logic [NUM_LANES-1:0]   en_out, en_pwm, out_lane;

   assign tick = (prescale_cnt_q == PW'(PRESCALE - 1));
   assign wrap = tick && (pwm_cnt_q == 8'hFF);

   always_comb begin
      prescale_cnt_d = tick ? '0 : prescale_cnt_q + PW'(1);
      pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prescale_cnt_q <= '0;
         pwm_cnt_q      <= 8'h00;
         period_start_q <= 1'b0;
      end else begin
         prescale_cnt_q <= prescale_cnt_d;
         pwm_cnt_q      <= pwm_cnt_d;
         period_start_q <= wrap;
      end

`ifdef PWM_SYNC_UPDATE_EN
   // Reload only at wrap so a running period is never cut short or stretched.
   logic [7:0] duty_eff_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)    duty_eff_q <= 8'h00;
      else if (wrap) duty_eff_q <= bus.pwm_duty_cycle;
   assign duty_eff = duty_eff_q;
`else
   assign duty_eff = bus.pwm_duty_cycle;
`endif

   // 0xFF is forced to a solid 1 so full duty has no one-step dip at cnt=255.
   assign pwm_level = (duty_eff == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_eff);

   assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
   assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      pwm_output_lane u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .en_out_i    (en_out[i]),
         .en_pwm_i    (en_pwm[i]),
         .pwm_level_i (pwm_level),
         .out_o       (out_lane[i])
      );
   end

   assign bus.out          = out_lane;
   assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed checks of the PWM output stage: static pins, duty ratios, gating,
// duty update timing and mid-period reset.
module tb_pwm_output_stage;
   localparam int PERIOD = 256 * 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   pwm_output_stage_if bus ();

   pwm_output_stage #(.PRESCALE(13)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      bus.en_reg_out_7_0  = eo[7:0];
      bus.en_reg_out_15_8 = eo[15:8];
      bus.en_reg_pwm_7_0  = ep[7:0];
      bus.en_reg_pwm_15_8 = ep[15:8];
      bus.pwm_duty_cycle  = d;
   endtask

   // Leaves the bench at the sample just after a wrap edge.
   task automatic wait_ps(input string tag);
      int k;
      k = 0;
      while (bus.period_start !== 1'b1 && k < PERIOD + 100) begin
         cyc(1);
         k++;
      end
      if (bus.period_start !== 1'b1) chk({tag, "_timeout"}, 32'(bus.period_start), 32'd1);
   endtask

   // Counts cycles with out[0] high; any activity on out[15:1] is tallied too.
   task automatic count_hi(input int n, output int hi, output int stray);
      hi = 0;
      stray = 0;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         if (bus.out[0] === 1'b1) hi++;
         if (bus.out[15:1] !== 15'd0) stray++;
      end
   endtask

   initial begin
      int hi, st, k;
      set_regs(16'hFFFF, 16'h0000, 8'h5A);

      // reset state
      cyc(2);
      chk("rst_out", 32'(bus.out), 32'h0);
      chk("rst_ps", 32'(bus.period_start), 32'd0);

      // 1: static high on all pins one clk after release
      rst_n = 1'b1;
      cyc(1);
      chk("static_1clk", 32'(bus.out), 32'hFFFF);
      cyc(50);
      chk("static_hold", 32'(bus.out), 32'hFFFF);

      // 2: 50% duty on pin 0 only
      set_regs(16'h0001, 16'h0001, 8'h80);
      wait_ps("t2");
      count_hi(PERIOD, hi, st);
      chk("duty80_hi", 32'(hi), 32'd1664);
      chk("duty80_stray", 32'(st), 32'd0);
      chk("duty80_ps", 32'(bus.period_start), 32'd1);

      // 3: duty 0 never high, duty FF never low across wraps
      bus.pwm_duty_cycle = 8'h00;
      wait_ps("t3a");
      count_hi(PERIOD, hi, st);
      chk("duty00_hi", 32'(hi), 32'd0);
      bus.pwm_duty_cycle = 8'hFF;
      wait_ps("t3b");
      count_hi(3 * PERIOD, hi, st);
      chk("dutyFF_hi", 32'(hi), 32'(3 * PERIOD));

      // 4: PWM selected but pin disabled stays low; enabling takes one edge
      set_regs(16'h0000, 16'h0001, 8'hFF);
      cyc(1);
      chk("gated_off", 32'(bus.out), 32'h0);
      set_regs(16'h0001, 16'h0001, 8'hFF);
      cyc(1);
      chk("gated_on", 32'(bus.out), 32'h1);

      // 5: duty 0x40 -> 0xC0 halfway through a period
      bus.pwm_duty_cycle = 8'h40;
      wait_ps("t5a");
      wait_ps("t5b");
      count_hi(PERIOD / 2, hi, st);
      chk("upd_first_half", 32'(hi), 32'd832);
      bus.pwm_duty_cycle = 8'hC0;
      count_hi(PERIOD / 2, hi, st);
`ifdef PWM_SYNC_UPDATE_EN
      chk("upd_second_half", 32'(hi), 32'd0);
`else
      chk("upd_second_half", 32'(hi), 32'd832);
`endif
      chk("upd_wrap_ps", 32'(bus.period_start), 32'd1);
      count_hi(PERIOD, hi, st);
      chk("upd_next_period", 32'(hi), 32'd2496);

`ifndef PWM_SYNC_UPDATE_EN
      // immediate effect: mid-period at cnt~0x60, raising duty lifts the pin next edge
      bus.pwm_duty_cycle = 8'h40;
      wait_ps("t5c");
      cyc(8'h60 * 13);
      chk("upd_pre", 32'(bus.out[0]), 32'd0);
      bus.pwm_duty_cycle = 8'hC0;
      cyc(1);
      chk("upd_1clk", 32'(bus.out[0]), 32'd1);
`endif

      // 6: async reset mid-period, then full period to first marker
      bus.pwm_duty_cycle = 8'h80;
      wait_ps("t6");
      cyc(100);
      chk("prerst_hi", 32'(bus.out[0]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", 32'(bus.out), 32'h0);
      cyc(1);
      rst_n = 1'b1;
      k = 0;
      while (bus.period_start !== 1'b1 && k < PERIOD + 100) begin
         cyc(1);
         k++;
      end
      chk("rst_to_ps", 32'(k), 32'(PERIOD));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
